// File: rtl/tx_gmii_sender.sv
// tx_gmii_sender: final TX stage of an output port.
// Drains the show-ahead packet FIFO (139-bit words) and its valid FIFO, and serialises each frame
// onto 8-bit GMII with preamble/SFD and a minimum inter-frame gap. Packets marked invalid are
// dropped silently; malformed packets are aborted with one txer cycle and then discarded.
// The FCS is already part of the data.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   in_pkt_q/empty      head word and empty flag of the packet FIFO
//   in_pkt_rdreq        packet FIFO pop (combinational)
//   in_valid_q/empty    head entry and empty flag of the valid FIFO
//   in_valid_rdreq      valid FIFO pop (combinational)
//   gmii_txd/txen/txer  registered GMII transmit outputs
//   tx_frame_cnt        frames fully sent (wraps)
//   tx_err_cnt          frames aborted as malformed (saturates)
module tx_gmii_sender #(
  parameter int unsigned PREAMBLE_LEN = 7,
  parameter int unsigned IFG_BYTES    = 12
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [138:0] in_pkt_q,
  input  logic         in_pkt_empty,
  output logic         in_pkt_rdreq,
  input  logic         in_valid_q,
  input  logic         in_valid_empty,
  output logic         in_valid_rdreq,
  output logic [7:0]   gmii_txd,
  output logic         gmii_txen,
  output logic         gmii_txer,
  output logic [31:0]  tx_frame_cnt,
  output logic [15:0]  tx_err_cnt
);

  localparam logic [2:0] TypeHead = 3'b101;
  localparam logic [2:0] TypeMid  = 3'b100;
  localparam logic [2:0] TypeTail = 3'b110;

  // StAbort is the single txer cycle emitted when a frame is cut short.
  typedef enum logic [2:0] {
    StIdle, StPreamble, StSfd, StData, StAbort, StIfg, StDiscard
  } state_e;

  state_e        state_q, state_d;
  // Latched word keeps type, last index and data; bits [131:128] are not needed.
  logic [134:0]  word_q, word_d;
  logic [3:0]    idx_q, idx_d;
  logic [4:0]    cnt_q, cnt_d;
  logic          abort_ifg_q, abort_ifg_d;
  logic [7:0]    txd_q, txd_d;
  logic          txen_q, txen_d;
  logic          txer_q, txer_d;
  logic [31:0]   frame_cnt_q;
  logic [15:0]   err_cnt_q;
  logic          frame_inc, err_inc;

  logic [2:0]    head_type;
  logic [2:0]    word_type;
  logic [134:0]  head_word;
  logic [7:0]    cur_byte;
  logic          unused_bits;

  assign head_type   = in_pkt_q[138:136];
  assign head_word   = {in_pkt_q[138:132], in_pkt_q[127:0]};
  assign word_type   = word_q[134:132];
  // Byte 0 sits in the top byte, so byte idx starts at bit 8*(15-idx) = {~idx, 3'b0}.
  assign cur_byte    = word_q[{~idx_q, 3'b000} +: 8];
  assign unused_bits = ^in_pkt_q[131:128];

  always_comb begin
    state_d        = state_q;
    word_d         = word_q;
    idx_d          = idx_q;
    cnt_d          = cnt_q;
    abort_ifg_d    = abort_ifg_q;
    txd_d          = 8'h00;
    txen_d         = 1'b0;
    txer_d         = 1'b0;
    in_pkt_rdreq   = 1'b0;
    in_valid_rdreq = 1'b0;
    frame_inc      = 1'b0;
    err_inc        = 1'b0;
    case (state_q)
      StIdle: begin
        if (!in_valid_empty) begin
          in_valid_rdreq = 1'b1;
          cnt_d          = 5'(PREAMBLE_LEN - 1);
          state_d        = in_valid_q ? StPreamble : StDiscard;
        end
      end
      StPreamble: begin
        txd_d  = 8'h55;
        txen_d = 1'b1;
        if (cnt_q != 5'd0) begin
          cnt_d = cnt_q - 5'd1;
        end else if (!in_pkt_empty && head_type == TypeHead) begin
          in_pkt_rdreq = 1'b1;
          word_d       = head_word;
          state_d      = StSfd;
        end else begin
          // A stray tail is consumed here, so the frame is already fully drained.
          abort_ifg_d  = !in_pkt_empty && head_type == TypeTail;
          in_pkt_rdreq = !in_pkt_empty && head_type == TypeTail;
          state_d      = StAbort;
        end
      end
      StSfd: begin
        txd_d   = 8'hD5;
        txen_d  = 1'b1;
        idx_d   = 4'd0;
        state_d = StData;
      end
      StData: begin
        txd_d  = cur_byte;
        txen_d = 1'b1;
        if (word_type == TypeTail && idx_q == word_q[131:128]) begin
          frame_inc = 1'b1;
          cnt_d     = 5'(IFG_BYTES - 2);
          state_d   = StIfg;
        end else if (idx_q == 4'hF) begin
          if (in_pkt_empty) begin
            abort_ifg_d = 1'b0;
            state_d     = StAbort;
          end else begin
            in_pkt_rdreq = 1'b1;
            word_d       = head_word;
            idx_d        = 4'd0;
            if (head_type != TypeMid && head_type != TypeTail) begin
              abort_ifg_d = 1'b0;
              state_d     = StAbort;
            end
          end
        end else begin
          idx_d = idx_q + 4'd1;
        end
      end
      StAbort: begin
        txen_d  = 1'b1;
        txer_d  = 1'b1;
        err_inc = 1'b1;
        cnt_d   = 5'(IFG_BYTES - 2);
        state_d = abort_ifg_q ? StIfg : StDiscard;
      end
      StIfg: begin
        if (cnt_q == 5'd0) begin
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StDiscard: begin
        if (!in_pkt_empty) begin
          in_pkt_rdreq = 1'b1;
          if (head_type == TypeTail) begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      word_q      <= '0;
      idx_q       <= 4'd0;
      cnt_q       <= 5'd0;
      abort_ifg_q <= 1'b0;
      txd_q       <= 8'h00;
      txen_q      <= 1'b0;
      txer_q      <= 1'b0;
      frame_cnt_q <= 32'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      abort_ifg_q <= abort_ifg_d;
      txd_q       <= txd_d;
      txen_q      <= txen_d;
      txer_q      <= txer_d;
      if (frame_inc) begin
        frame_cnt_q <= frame_cnt_q + 32'd1;
      end
      if (err_inc && err_cnt_q != 16'hFFFF) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign gmii_txd     = txd_q;
  assign gmii_txen    = txen_q;
  assign gmii_txer    = txer_q;
  assign tx_frame_cnt = frame_cnt_q;
  assign tx_err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_tx_gmii_sender.sv
// Scoreboard bench for tx_gmii_sender: stimulus pushes words into a modelled show-ahead FIFO
// and the expected wire bytes into a queue; a negedge monitor compares every txen cycle.
module tb_tx_gmii_sender;

  logic         clk = 1'b0;
  logic         reset = 1'b0;
  logic [138:0] in_pkt_q;
  logic         in_pkt_empty;
  logic         in_pkt_rdreq;
  logic         in_valid_q;
  logic         in_valid_empty;
  logic         in_valid_rdreq;
  logic [7:0]   gmii_txd;
  logic         gmii_txen;
  logic         gmii_txer;
  logic [31:0]  tx_frame_cnt;
  logic [15:0]  tx_err_cnt;

  always #4 clk = ~clk;

  tx_gmii_sender dut (
    .clk            (clk),
    .reset          (reset),
    .in_pkt_q       (in_pkt_q),
    .in_pkt_empty   (in_pkt_empty),
    .in_pkt_rdreq   (in_pkt_rdreq),
    .in_valid_q     (in_valid_q),
    .in_valid_empty (in_valid_empty),
    .in_valid_rdreq (in_valid_rdreq),
    .gmii_txd       (gmii_txd),
    .gmii_txen      (gmii_txen),
    .gmii_txer      (gmii_txer),
    .tx_frame_cnt   (tx_frame_cnt),
    .tx_err_cnt     (tx_err_cnt)
  );

  // FIFO models
  logic [138:0] mem [256];
  logic         vmem [256];
  int unsigned  wr = 0, rd = 0, vwr = 0, vrd = 0;
  int unsigned  pkt_pops = 0, valid_pops = 0;
  bit           flush_fifo = 1'b0;
  bit           flush_exp = 1'b0;

  assign in_pkt_q       = mem[rd[7:0]];
  assign in_pkt_empty   = (rd == wr);
  assign in_valid_q     = vmem[vrd[7:0]];
  assign in_valid_empty = (vrd == vwr);

  always @(posedge clk) begin
    if (flush_fifo) begin
      rd  <= wr;
      vrd <= vwr;
    end else begin
      if (in_pkt_rdreq) begin
        rd       <= rd + 1;
        pkt_pops <= pkt_pops + 1;
      end
      if (in_valid_rdreq) begin
        vrd        <= vrd + 1;
        valid_pops <= valid_pops + 1;
      end
    end
  end

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input longint got, input longint want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, got, want);
    end
  endtask

  // Scoreboard: {txer, txd} per txen-high cycle
  logic [8:0] exp_q[$];
  int low_run = 0, high_run = 0, last_gap = 0, last_high = 0;
  bit txen_prev = 1'b0;

  always @(negedge clk) begin
    if (flush_exp) exp_q.delete();
    if (gmii_txen) begin
      if (!txen_prev) last_gap = low_run;
      low_run = 0;
      high_run++;
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_txen: got txd %0h, expected no transmission", gmii_txd);
      end else begin
        check("wire_byte", {gmii_txer, gmii_txd}, exp_q.pop_front());
      end
    end else begin
      if (txen_prev) last_high = high_run;
      high_run = 0;
      low_run++;
    end
    txen_prev = gmii_txen;
  end

  function automatic logic [138:0] mk_word(input logic [2:0] typ, input logic [3:0] last,
                                           input logic [7:0] base);
    logic [138:0] w;
    w = '0;
    w[138:136] = typ;
    w[135:132] = last;
    for (int k = 0; k < 16; k++) w[127 - 8*k -: 8] = base + 8'(k);
    return w;
  endfunction

  task automatic push_word(input logic [138:0] w);
    mem[wr[7:0]] = w;
    wr = wr + 1;
  endtask

  task automatic push_valid(input bit v);
    vmem[vwr[7:0]] = v;
    vwr = vwr + 1;
  endtask

  task automatic exp_preamble();
    for (int i = 0; i < 7; i++) exp_q.push_back(9'h055);
    exp_q.push_back(9'h0D5);
  endtask

  // Well-formed packet of nw words; byte k of word w is base+16*w+k.
  task automatic push_pkt(input int nw, input int last, input logic [7:0] base, input bit v);
    logic [2:0] typ;
    for (int w = 0; w < nw; w++) begin
      typ = (w == 0) ? 3'b101 : (w == nw - 1) ? 3'b110 : 3'b100;
      push_word(mk_word(typ, (w == nw - 1) ? 4'(last) : 4'd0, base + 8'(16 * w)));
    end
    if (v) begin
      exp_preamble();
      for (int w = 0; w < nw; w++)
        for (int k = 0; k < ((w == nw - 1) ? last + 1 : 16); k++)
          exp_q.push_back({1'b0, base + 8'(16 * w + k)});
    end
  endtask

  task automatic drain(input string name);
    int n = 0;
    while ((exp_q.size() != 0 || gmii_txen) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    if (n >= 3000) begin
      tests++;
      fails++;
      $display("FAIL %s_timeout: got %0d pending bytes, expected 0", name, exp_q.size());
    end
    repeat (20) @(negedge clk);
  endtask

  int p0, v0;

  initial begin
    repeat (3) @(negedge clk);
    check("reset_txen", gmii_txen, 0);
    check("reset_txd", gmii_txd, 0);
    check("reset_frames", tx_frame_cnt, 0);
    check("reset_errs", tx_err_cnt, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // 64-byte frame
    p0 = pkt_pops; v0 = valid_pops;
    push_pkt(4, 15, 8'h00, 1'b1);
    push_valid(1'b1);
    drain("f64");
    check("f64_len", last_high, 72);
    check("f64_frames", tx_frame_cnt, 1);
    check("f64_pops", pkt_pops - p0, 4);
    check("f64_vpops", valid_pops - v0, 1);

    // 60-byte frame
    push_pkt(4, 11, 8'h40, 1'b1);
    push_valid(1'b1);
    drain("f60");
    check("f60_len", last_high, 68);
    check("f60_frames", tx_frame_cnt, 2);

    // Back-to-back frames
    push_pkt(4, 15, 8'h80, 1'b1);
    push_pkt(4, 15, 8'hC0, 1'b1);
    push_valid(1'b1);
    push_valid(1'b1);
    drain("b2b");
    check("b2b_gap", last_gap, 12);
    check("b2b_frames", tx_frame_cnt, 4);

    // Dropped packet then valid frame
    p0 = pkt_pops;
    push_pkt(5, 7, 8'h10, 1'b0);
    push_pkt(4, 15, 8'h20, 1'b1);
    push_valid(1'b0);
    push_valid(1'b1);
    drain("drop");
    check("drop_pops", pkt_pops - p0, 9);
    check("drop_errs", tx_err_cnt, 0);
    check("drop_frames", tx_frame_cnt, 5);

    // Malformed: header, middle, header, middle, tail
    p0 = pkt_pops;
    push_word(mk_word(3'b101, 4'd0, 8'h30));
    push_word(mk_word(3'b100, 4'd0, 8'h40));
    push_word(mk_word(3'b101, 4'd0, 8'h50));
    push_word(mk_word(3'b100, 4'd0, 8'h60));
    push_word(mk_word(3'b110, 4'd3, 8'h70));
    exp_preamble();
    for (int k = 0; k < 32; k++) exp_q.push_back({1'b0, 8'h30 + 8'(k)});
    exp_q.push_back(9'h100);
    push_valid(1'b1);
    drain("bad");
    check("bad_len", last_high, 41);
    check("bad_errs", tx_err_cnt, 1);
    check("bad_frames", tx_frame_cnt, 5);
    check("bad_pops", pkt_pops - p0, 5);
    check("bad_fifo_empty", in_pkt_empty, 1);

    // Reset at data byte 20
    push_pkt(4, 15, 8'h00, 1'b1);
    push_valid(1'b1);
    begin
      int n = 0;
      while (exp_q.size() > 44 && n < 500) begin
        @(posedge clk);
        n++;
      end
      check("rst_reached_byte20", exp_q.size(), 44);
    end
    #2 reset = 1'b0;
    #1;
    check("rst_txen", gmii_txen, 0);
    check("rst_txer", gmii_txer, 0);
    check("rst_txd", gmii_txd, 0);
    check("rst_frames", tx_frame_cnt, 0);
    check("rst_errs", tx_err_cnt, 0);
    flush_exp  = 1'b1;
    flush_fifo = 1'b1;
    @(negedge clk);
    @(negedge clk);
    flush_exp  = 1'b0;
    flush_fifo = 1'b0;
    reset = 1'b1;
    v0 = valid_pops;
    repeat (30) @(negedge clk);
    check("idle_vpops", valid_pops - v0, 0);
    check("idle_txen", gmii_txen, 0);
    push_pkt(2, 0, 8'hA0, 1'b1);
    push_valid(1'b1);
    drain("post_rst");
    check("post_rst_len", last_high, 25);
    check("post_rst_frames", tx_frame_cnt, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tx_gmii_sender.md
Name: tx_gmii_sender

Overview:
- Final TX stage of an output port; sits directly downstream of the CRC-append stage.
- Drains the 139-bit port packet FIFO and its 1-bit valid FIFO (both show-ahead, written by the CRC stage) and serialises each frame onto an 8-bit GMII transmit interface.
- Inserts preamble and SFD, enforces the inter-frame gap, and discards packets marked invalid or found malformed.
- The FCS is already in the data; this block does not compute it.

Parameters:
- PREAMBLE_LEN, 7, number of 0x55 bytes sent before the SFD (legal range 1..15).
- IFG_BYTES, 12, minimum number of txen-low cycles between frames (legal range 2..31).

Ports:
- clk  in  1  system clock (125 MHz GMII TX clock).
- reset  in  1  asynchronous, active-low reset.
- in_pkt_q  in  139  show-ahead head word of the packet FIFO.
  - [138:136]: 101 header, 100 middle, 110 tail.
  - [135:132]: index of the last valid byte in a tail word.
  - [127:0]: data, byte0 at [127:120].
- in_pkt_empty  in  1  packet FIFO empty.
- in_pkt_rdreq  out  1  pop packet FIFO (combinational).
- in_valid_q  in  1  show-ahead head of the valid FIFO (1 = send, 0 = drop).
- in_valid_empty  in  1  valid FIFO empty.
- in_valid_rdreq  out  1  pop valid FIFO (combinational).
- gmii_txd  out  8  transmit data (registered).
- gmii_txen  out  1  transmit enable (registered).
- gmii_txer  out  1  transmit error (registered).
- tx_frame_cnt  out  32  frames fully sent, wraps at 2^32.
- tx_err_cnt  out  16  frames aborted or discarded as malformed, saturates at 0xFFFF.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; gmii_txd=0, gmii_txen=0, gmii_txer=0; both counters 0; word register and byte index 0.
  - A reset mid-frame truncates the frame immediately, with no txer.
- rdreq generation: both rdreq outputs are combinational. in_pkt_rdreq is always gated with !in_pkt_empty. A word is popped in the same cycle it is latched.
- States: IDLE, PREAMBLE, SFD, DATA, IFG, DISCARD.
- IDLE (txen=0):
  - If !in_valid_empty: assert in_valid_rdreq.
  - in_valid_q=1 → PREAMBLE. in_valid_q=0 → DISCARD.
- PREAMBLE: txd=0x55, txen=1 for PREAMBLE_LEN cycles; counter pre-loaded on the IDLE exit edge.
  - In the last preamble cycle: check the head word.
  - If !in_pkt_empty and type=101: latch it and assert in_pkt_rdreq.
  - Otherwise: abort.
- SFD: txd=0xD5, txen=1 for 1 cycle; byte index=0.
- DATA: txd = latched word byte[idx], txen=1, idx increments each cycle.
  - At idx=15 on a non-tail word: latch the head word with in_pkt_rdreq and reset idx to 0.
    - Next type 100 or 110: continue.
    - Next type 101, or FIFO empty: abort.
  - On a tail word, when idx=[135:132]: the last byte is sent; next state IFG; tx_frame_cnt+1.
- Abort path (from PREAMBLE or DATA):
  - Drive one cycle of txd=0, txen=1, txer=1.
  - tx_err_cnt+1.
  - Go to DISCARD, unless the offending word was a tail, in which case go to IFG.
- IFG: txen=0, txer=0, txd=0 for IFG_BYTES-1 cycles, then IDLE.
  - Back-to-back frames therefore see exactly IFG_BYTES txen-low cycles (the IFG cycles plus the IDLE decision cycle).
- DISCARD: txen=0. in_pkt_rdreq=!in_pkt_empty every cycle. When a popped word has type 110 → IDLE. Words popped: all words up to and including the first tail.
- Frame length on the wire = PREAMBLE_LEN + 1 + 16·(words−1) + ([135:132] of the tail) + 1.
- Simultaneous events: the valid FIFO is sampled only in IDLE; new packets arriving during DATA or IFG wait. Counter wrap and saturation follow the port definitions.

Test Plan:
- 64-byte frame (4 words, tail idx 15, valid=1) → txen high 72 consecutive cycles: 7×0x55, 0xD5, 64 data bytes in order. Then txen low. tx_frame_cnt=1. Exactly 4 in_pkt_rdreq pulses and 1 in_valid_rdreq pulse.
- 60-byte frame (tail idx 11) → txen high 68 cycles; the last txd equals tail byte 11; bytes 12–15 are never driven.
- Two 64-byte frames queued back-to-back → exactly 12 txen-low cycles between them; tx_frame_cnt=2.
- Valid=0 packet of 5 words followed by a valid 64-byte frame → no txen for the first; 5 pops in DISCARD; the second frame is sent intact; tx_err_cnt=0.
- Malformed packet: header, middle, then header again → after 32 data bytes, one cycle txen=1, txer=1. Discard runs to the next tail; tx_err_cnt=1; no frame count increment.
- reset driven low at data byte 20 → txen, txer and txd go 0 asynchronously and counters clear. After release the block idles until in_valid_empty=0.
